lif_layer_sequencer: RTL

//  Time-multiplexed LIF layer controller; drives one combinational `neuron` instance (MAC, decay, clamp, reset).

---
 rtl/lif_layer_sequencer_if.sv | 24 ++
 rtl/lif_layer_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/lif_layer_sequencer_if.sv
// rtl/lif_layer_sequencer_if.sv - spike-vector input and output stream bundle for the LIF layer sequencer
interface lif_layer_sequencer_if #(
    parameter int N_IN      = 8,
    parameter int N_NEURONS = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [N_IN-1:0]      in_spikes;
    logic                 out_valid;
    logic                 out_ready;
    logic [N_NEURONS-1:0] out_spikes;

    // Upstream/downstream side: supplies input spikes, consumes the output vector
    modport master (
        output in_valid, in_spikes, out_ready,
        input  in_ready, out_valid, out_spikes
    );

    // Sequencer side
    modport slave (
        input  in_valid, in_spikes, out_ready,
        output in_ready, out_valid, out_spikes
    );
endinterface

// File: rtl/lif_layer_sequencer.sv
// rtl/lif_layer_sequencer.sv - time-multiplexed LIF layer controller with a shared combinational neuron
module neuron #(
    parameter int N_STAGE     = 3,
    parameter int N_MEMBRANE  = N_STAGE + 2,
    parameter int N_THRESHOLD = N_MEMBRANE - 1
) (
    input  logic [2**N_STAGE-1:0]         spikes_i,
    input  logic [2**N_STAGE-1:0]         weights_i,
    input  logic signed [N_MEMBRANE-1:0]  membrane_i,
    input  logic [N_THRESHOLD-1:0]        threshold_i,
    input  logic [2:0]                    shift_i,
    output logic signed [N_MEMBRANE-1:0]  new_membrane_o,
    output logic                          is_spike_o
);
    localparam int NIN = 2**N_STAGE;
    // Two guard bits so the sum of a full-scale membrane and a full fan-in never wraps before clamping
    localparam int W   = N_MEMBRANE + 2;
    localparam logic signed [W-1:0] MAXV = W'((2**(N_MEMBRANE-1)) - 1);
    localparam logic signed [W-1:0] MINV = W'(-(2**(N_MEMBRANE-1)));

    logic [N_STAGE:0]               sum;
    logic signed [N_MEMBRANE-1:0]   decayed;
    logic signed [W-1:0]            acc;
    logic signed [W-1:0]            clamped;
    logic signed [W-1:0]            thr_ext;
    logic signed [W-1:0]            after_fire;

    // Binary-weight MAC, shift decay, clamp to membrane range, reset by subtracting the threshold on a spike
    always_comb begin
        sum = '0;
        for (int i = 0; i < NIN; i++) begin
            sum = sum + {{N_STAGE{1'b0}}, (spikes_i[i] & weights_i[i])};
        end
        decayed = membrane_i >>> shift_i;
        acc     = {{(W-N_MEMBRANE){decayed[N_MEMBRANE-1]}}, decayed}
                + {{(W-N_STAGE-1){1'b0}}, sum};
        if (acc > MAXV) begin
            clamped = MAXV;
        end else if (acc < MINV) begin
            clamped = MINV;
        end else begin
            clamped = acc;
        end
        thr_ext        = {{(W-N_THRESHOLD){1'b0}}, threshold_i};
        is_spike_o     = (clamped >= thr_ext);
        after_fire     = is_spike_o ? (clamped - thr_ext) : clamped;
        new_membrane_o = after_fire[N_MEMBRANE-1:0];
    end
endmodule

module lif_layer_sequencer #(
    parameter int N_STAGE     = 3,
    parameter int N_MEMBRANE  = N_STAGE + 2,
    parameter int N_THRESHOLD = N_MEMBRANE - 1,
    parameter int N_NEURONS   = 4,
    parameter int IDXW        = $clog2(N_NEURONS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_we_i,
    input  logic [1:0]                   cfg_sel_i,
    input  logic [IDXW-1:0]              cfg_idx_i,
    input  logic [2**N_STAGE-1:0]        cfg_data_i,
    input  logic [IDXW-1:0]              dbg_idx_i,
    output logic signed [N_MEMBRANE-1:0] dbg_membrane_o,
    lif_layer_sequencer_if.slave         s_if
);
    localparam int NIN   = 2**N_STAGE;
    localparam int NSLOT = 2**IDXW;
    // Bit i set when index i names a real neuron; avoids range compares on narrow indices
    localparam logic [NSLOT-1:0] IDX_MASK = NSLOT'((65'(1) << N_NEURONS) - 65'(1));
    localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(N_NEURONS - 1);

    typedef enum logic [1:0] {IDLE, STEP, OUT} state_t;

    state_t                         state_q, state_d;
    logic [IDXW-1:0]                idx_q;
    logic [NIN-1:0]                 spikes_q;
    logic [N_NEURONS-1:0]           spk_q;
    logic [N_NEURONS-1:0]           spk_d;
    logic [N_NEURONS-1:0]           out_spikes_q;
    logic [NIN-1:0]                 weights_q  [N_NEURONS];
    logic [N_THRESHOLD-1:0]         thr_q      [N_NEURONS];
    logic signed [N_MEMBRANE-1:0]   mem_q      [N_NEURONS];
    logic [2:0]                     shift_q;

    logic                           in_ready;
    logic                           out_valid;
    logic signed [N_MEMBRANE-1:0]   new_membrane;
    logic                           is_spike;

    neuron #(
        .N_STAGE     (N_STAGE),
        .N_MEMBRANE  (N_MEMBRANE),
        .N_THRESHOLD (N_THRESHOLD)
    ) u_neuron (
        .spikes_i       (spikes_q),
        .weights_i      (weights_q[idx_q]),
        .membrane_i     (mem_q[idx_q]),
        .threshold_i    (thr_q[idx_q]),
        .shift_i        (shift_q),
        .new_membrane_o (new_membrane),
        .is_spike_o     (is_spike)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and Moore handshake outputs
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (s_if.in_valid) state_d = STEP;
            end
            STEP: begin
                if (idx_q == LAST_IDX) state_d = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (s_if.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Spike vector with the current neuron's result merged in
    always_comb begin
        spk_d        = spk_q;
        spk_d[idx_q] = is_spike;
    end

    // Configuration, input latch and per-neuron write-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q        <= '0;
            spikes_q     <= '0;
            spk_q        <= '0;
            out_spikes_q <= '0;
            shift_q      <= '0;
            for (int k = 0; k < N_NEURONS; k++) begin
                weights_q[k] <= '0;
                thr_q[k]     <= '1;
                mem_q[k]     <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    // Writes land on the accept edge, so they apply to the timestep being accepted
                    if (cfg_we_i) begin
                        case (cfg_sel_i)
                            2'b00: if (IDX_MASK[cfg_idx_i]) weights_q[cfg_idx_i] <= cfg_data_i;
                            2'b01: if (IDX_MASK[cfg_idx_i]) thr_q[cfg_idx_i] <= cfg_data_i[N_THRESHOLD-1:0];
                            2'b10: shift_q <= cfg_data_i[2:0];
                            default: begin
                                for (int k = 0; k < N_NEURONS; k++) mem_q[k] <= '0;
                            end
                        endcase
                    end
                    if (s_if.in_valid) begin
                        spikes_q <= s_if.in_spikes;
                        idx_q    <= '0;
                    end
                end
                STEP: begin
                    mem_q[idx_q] <= new_membrane;
                    spk_q        <= spk_d;
                    if (idx_q == LAST_IDX) begin
                        out_spikes_q <= spk_d;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s_if.in_ready   = in_ready;
    assign s_if.out_valid  = out_valid;
    assign s_if.out_spikes = out_spikes_q;
    assign dbg_membrane_o  = IDX_MASK[dbg_idx_i] ? mem_q[dbg_idx_i] : '0;
endmodule
